// File: rtl/adin_sample_sequencer.sv
// adin_sample_sequencer
// Scans a masked set of analog channels through the shared sampling capacitor.
// For each channel it discharges the capacitor, leaves one break-before-make
// gap cycle, samples the channel, then holds while the SAR converts. Each result
// is returned together with its channel index. All outputs come from registers.
module adin_sample_sequencer #(
  parameter int NCH   = 8,
  parameter int CH_W  = 3,
  parameter int CNT_W = 8,
  parameter int DW    = 10
) (
  input  logic             i_clk,
  input  logic             i_resb,
  input  logic             i_en,
  input  logic             i_cont,
  input  logic             i_trig,
  input  logic [NCH-1:0]   i_ch_mask,
  input  logic [CNT_W-1:0] i_pre_time,
  input  logic [CNT_W-1:0] i_smp_time,
  input  logic             i_conv_ack,
  input  logic [DW-1:0]    i_conv_data,
  output logic             o_dischg,
  output logic [NCH-1:0]   o_smp_sw,
  output logic             o_hold,
  output logic             o_conv_req,
  output logic [DW-1:0]    o_res_data,
  output logic [CH_W-1:0]  o_res_ch,
  output logic             o_res_vld,
  output logic             o_busy,
  output logic             o_scan_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DISCH  = 3'd1,
    S_GAP    = 3'd2,
    S_SAMPLE = 3'd3,
    S_CONV   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   w_pend_next;
  logic [CH_W-1:0]  r_ch;
  logic [CH_W-1:0]  w_ch_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic [DW-1:0]    r_res_data;
  logic [DW-1:0]    w_res_data_next;
  logic [CH_W-1:0]  r_res_ch;
  logic [CH_W-1:0]  w_res_ch_next;
  logic             r_res_vld;
  logic             w_res_vld_next;
  logic             r_scan_done;
  logic             w_scan_done_next;

  logic             r_dischg;
  logic [NCH-1:0]   r_smp_sw;
  logic             r_hold;
  logic             r_conv_req;
  logic             r_busy;

  logic [CNT_W-1:0] w_pre_load;
  logic [CNT_W-1:0] w_smp_load;
  logic [NCH-1:0]   w_cur_onehot;
  logic [NCH-1:0]   w_pend_cleared;
  logic [NCH-1:0]   w_smp_sw_next;

  // Zero-length phases are stretched to one cycle.
  assign w_pre_load = (i_pre_time == '0) ? CNT_W'(1) : i_pre_time;
  assign w_smp_load = (i_smp_time == '0) ? CNT_W'(1) : i_smp_time;

  // Lowest-index set bit of a channel mask.
  function automatic logic [CH_W-1:0] f_lowest(input logic [NCH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // Per-channel decodes: current channel (for pending-bit clear) and the
  // sample switch pattern for the next cycle (one-hot, only in SAMPLE).
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch_dec
      assign w_cur_onehot[gi]  = (r_ch == CH_W'(gi));
      assign w_smp_sw_next[gi] = (w_state_next == S_SAMPLE) && (w_ch_next == CH_W'(gi));
    end
  endgenerate

  assign w_pend_cleared = r_pend & ~w_cur_onehot;

  // Next-state, counter, pending mask and result logic.
  always_comb begin
    w_state_next     = r_state;
    w_pend_next      = r_pend;
    w_ch_next        = r_ch;
    w_cnt_next       = r_cnt;
    w_res_data_next  = r_res_data;
    w_res_ch_next    = r_res_ch;
    w_res_vld_next   = 1'b0;
    w_scan_done_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_trig && i_en && (i_ch_mask != '0)) begin
          w_pend_next  = i_ch_mask;
          w_ch_next    = f_lowest(i_ch_mask);
          w_cnt_next   = w_pre_load;
          w_state_next = S_DISCH;
        end
      end

      S_DISCH: begin
        if (!i_en) begin
          w_pend_next  = '0;
          w_state_next = S_IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_next = S_GAP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      S_GAP: begin
        if (!i_en) begin
          w_pend_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next   = w_smp_load;
          w_state_next = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (!i_en) begin
          w_pend_next  = '0;
          w_state_next = S_IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_next = S_CONV;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      S_CONV: begin
        // An abort request in CONV still lets the handshake finish so the
        // SAR is never left with an unanswered request.
        if (i_conv_ack) begin
          w_res_data_next = i_conv_data;
          w_res_ch_next   = r_ch;
          w_res_vld_next  = 1'b1;
          w_pend_next     = w_pend_cleared;
          if (!i_en) begin
            w_pend_next  = '0;
            w_state_next = S_IDLE;
          end else if (w_pend_cleared != '0) begin
            w_ch_next    = f_lowest(w_pend_cleared);
            w_cnt_next   = w_pre_load;
            w_state_next = S_DISCH;
          end else begin
            w_scan_done_next = 1'b1;
            if (i_cont && (i_ch_mask != '0)) begin
              w_pend_next  = i_ch_mask;
              w_ch_next    = f_lowest(i_ch_mask);
              w_cnt_next   = w_pre_load;
              w_state_next = S_DISCH;
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end
      end

      default: begin
        w_pend_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, counter and pending-mask registers.
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_ch    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_ch    <= w_ch_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Output registers, decoded from the next state so each output is high
  // exactly while the matching state is current.
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      r_dischg    <= 1'b0;
      r_smp_sw    <= '0;
      r_hold      <= 1'b0;
      r_conv_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_res_data  <= '0;
      r_res_ch    <= '0;
      r_res_vld   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_dischg    <= (w_state_next == S_DISCH);
      r_smp_sw    <= w_smp_sw_next;
      r_hold      <= (w_state_next == S_CONV);
      r_conv_req  <= (w_state_next == S_CONV);
      r_busy      <= (w_state_next != S_IDLE);
      r_res_data  <= w_res_data_next;
      r_res_ch    <= w_res_ch_next;
      r_res_vld   <= w_res_vld_next;
      r_scan_done <= w_scan_done_next;
    end
  end

  assign o_dischg    = r_dischg;
  assign o_smp_sw    = r_smp_sw;
  assign o_hold      = r_hold;
  assign o_conv_req  = r_conv_req;
  assign o_busy      = r_busy;
  assign o_res_data  = r_res_data;
  assign o_res_ch    = r_res_ch;
  assign o_res_vld   = r_res_vld;
  assign o_scan_done = r_scan_done;

endmodule

// File: tb/tb_adin_sample_sequencer.sv
// Testbench for adin_sample_sequencer: per-cycle vector table for single
// scans and ignored-input cases, plus hand-written multi-cycle sequences.
module tb_adin_sample_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, cont, trig, ack;
  logic [7:0] mask, pre, smp;
  logic [9:0] cdata;
  logic       o_dischg, o_hold, o_conv_req, o_res_vld, o_busy, o_scan_done;
  logic [7:0] o_smp_sw;
  logic [9:0] o_res_data;
  logic [2:0] o_res_ch;

  int n_checks = 0;
  int n_errors = 0;
  int n_vld    = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  adin_sample_sequencer #(.NCH(8), .CH_W(3), .CNT_W(8), .DW(10)) dut (
    .i_clk(clk), .i_resb(rst_n), .i_en(en), .i_cont(cont), .i_trig(trig),
    .i_ch_mask(mask), .i_pre_time(pre), .i_smp_time(smp),
    .i_conv_ack(ack), .i_conv_data(cdata),
    .o_dischg(o_dischg), .o_smp_sw(o_smp_sw), .o_hold(o_hold),
    .o_conv_req(o_conv_req), .o_res_data(o_res_data), .o_res_ch(o_res_ch),
    .o_res_vld(o_res_vld), .o_busy(o_busy), .o_scan_done(o_scan_done)
  );

  // Count result and end-of-scan strobes.
  always @(negedge clk) begin
    if (o_res_vld)   n_vld  <= n_vld + 1;
    if (o_scan_done) n_done <= n_done + 1;
  end

  typedef struct {
    logic        trig;
    logic        en;
    logic        cont;
    logic [7:0]  mask;
    logic [7:0]  pre;
    logic [7:0]  smp;
    logic        ack;
    logic [9:0]  data;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[40];
  int   n_vecs = 0;

  function automatic logic [26:0] E(input logic d, input logic [7:0] sw, input logic hr,
                                    input logic v, input logic dn, input logic b,
                                    input logic [2:0] ch, input logic [9:0] dat);
    return {d, sw, hr, hr, v, dn, b, ch, dat};
  endfunction

  function automatic logic [26:0] act_vec();
    return {o_dischg, o_smp_sw, o_hold, o_conv_req, o_res_vld, o_scan_done, o_busy,
            o_res_ch, o_res_data};
  endfunction

  task automatic add(input logic t, input logic e, input logic c, input logic [7:0] m,
                     input logic [7:0] p, input logic [7:0] s, input logic a,
                     input logic [9:0] d, input logic [26:0] x);
    vecs[n_vecs] = '{t, e, c, m, p, s, a, d, x};
    n_vecs++;
  endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end else begin
      $display("ok   %s: %h", name, a);
    end
  endtask

  // Wait (bounded) for CONV_REQ; reports the OR of SMP_SW seen meanwhile.
  task automatic wait_req(output bit ok, output logic [7:0] sw_seen);
    ok = 1'b0;
    sw_seen = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      sw_seen = sw_seen | o_smp_sw;
      if (o_conv_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sw(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_smp_sw != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Answer a pending request after 'delay' cycles; returns at the negedge
  // of the cycle following the acknowledging edge.
  task automatic do_ack(input logic [9:0] d, input int delay);
    repeat (delay) @(negedge clk);
    ack = 1'b1;
    cdata = d;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic start(input logic [7:0] m, input logic [7:0] p, input logic [7:0] s);
    mask = m; pre = p; smp = s; trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0;
  endtask

  bit         ok;
  logic [7:0] seen;
  int         snap_vld, snap_done;
  logic       held;

  initial begin
    rst_n = 1'b0; en = 1'b0; cont = 1'b0; trig = 1'b0; ack = 1'b0;
    mask = '0; pre = '0; smp = '0; cdata = '0;

    // Scan of ch0/ch2, PRE=2, SMP=3, ack on the 2nd request cycle.
    add(1,1,0,8'h05,2,3,0,0,     E(1,8'h00,0,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,0,0,     E(1,8'h00,0,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h00,0,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h01,0,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h01,0,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h01,0,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h00,1,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h00,1,0,0,1,0,10'h000));
    add(0,1,0,8'h05,2,3,1,10'h155, E(1,8'h00,0,1,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,0,0,     E(1,8'h00,0,0,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h00,0,0,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h04,0,0,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h04,0,0,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h04,0,0,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h00,1,0,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h00,1,0,0,1,0,10'h155));
    add(0,1,0,8'h05,2,3,1,10'h2AA, E(0,8'h00,0,1,1,0,2,10'h2AA));
    add(0,1,0,8'h05,2,3,0,0,     E(0,8'h00,0,0,0,0,2,10'h2AA));
    // Zero timing fields act as 1; single channel 7.
    add(1,1,0,8'h80,0,0,0,0,     E(1,8'h00,0,0,0,1,2,10'h2AA));
    add(0,1,0,8'h80,0,0,0,0,     E(0,8'h00,0,0,0,1,2,10'h2AA));
    add(0,1,0,8'h80,0,0,0,0,     E(0,8'h80,0,0,0,1,2,10'h2AA));
    add(0,1,0,8'h80,0,0,0,0,     E(0,8'h00,1,0,0,1,2,10'h2AA));
    add(0,1,0,8'h80,0,0,1,10'h3C3, E(0,8'h00,0,1,1,0,7,10'h3C3));
    add(0,1,0,8'h80,0,0,0,0,     E(0,8'h00,0,0,0,0,7,10'h3C3));
    // Ignored: TRIG with zero mask, TRIG with EN low, stray ack in IDLE.
    add(1,1,0,8'h00,1,1,0,0,     E(0,8'h00,0,0,0,0,7,10'h3C3));
    add(1,0,0,8'h01,1,1,0,0,     E(0,8'h00,0,0,0,0,7,10'h3C3));
    add(0,1,0,8'h01,1,1,1,10'h111, E(0,8'h00,0,0,0,0,7,10'h3C3));
    // TRIG repeated while busy has no effect on the running scan.
    add(1,1,0,8'h02,1,1,0,0,     E(1,8'h00,0,0,0,1,7,10'h3C3));
    add(1,1,0,8'h01,1,1,0,0,     E(0,8'h00,0,0,0,1,7,10'h3C3));
    add(0,1,0,8'h01,1,1,0,0,     E(0,8'h02,0,0,0,1,7,10'h3C3));
    add(1,1,0,8'h01,1,1,0,0,     E(0,8'h00,1,0,0,1,7,10'h3C3));
    add(0,1,0,8'h01,1,1,1,10'h0AB, E(0,8'h00,0,1,1,0,1,10'h0AB));
    add(0,1,0,8'h01,1,1,0,0,     E(0,8'h00,0,0,0,0,1,10'h0AB));

    #2;
    check("reset_async_state", {5'd0, act_vec()}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_released_idle", {5'd0, act_vec()}, 32'd0);

    for (int i = 0; i < n_vecs; i++) begin
      trig = vecs[i].trig; en = vecs[i].en; cont = vecs[i].cont;
      mask = vecs[i].mask; pre = vecs[i].pre; smp = vecs[i].smp;
      ack = vecs[i].ack; cdata = vecs[i].data;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), {5'd0, act_vec()}, {5'd0, vecs[i].exp});
    end
    trig = 1'b0; ack = 1'b0; en = 1'b1;

    // Continuous mode with the mask changed during the first scan.
    cont = 1'b1;
    start(8'h03, 8'd1, 8'd1);
    wait_req(ok, seen);
    check("cont_req1_seen", {31'd0, ok}, 32'd1);
    check("cont_sw1", {24'd0, seen}, 32'h01);
    mask = 8'h08;
    do_ack(10'h101, 1);
    check("cont_res1 vld/done/ch/dischg", {o_res_vld, o_scan_done, o_res_ch, o_dischg},
          {1'b1, 1'b0, 3'd0, 1'b1});
    wait_req(ok, seen);
    check("cont_sw2", {23'd0, ok, seen}, {23'd0, 1'b1, 8'h02});
    do_ack(10'h102, 0);
    check("cont_res2 vld/done/ch/dischg/busy",
          {o_res_vld, o_scan_done, o_res_ch, o_dischg, o_busy},
          {1'b1, 1'b1, 3'd1, 1'b1, 1'b1});
    cont = 1'b0;
    wait_req(ok, seen);
    check("cont_sw3", {23'd0, ok, seen}, {23'd0, 1'b1, 8'h08});
    do_ack(10'h103, 0);
    check("cont_res3 vld/done/ch/busy", {o_res_vld, o_scan_done, o_res_ch, o_busy},
          {1'b1, 1'b1, 3'd3, 1'b0});

    // EN dropped in SAMPLE: abort, no strobes.
    @(negedge clk);
    start(8'h01, 8'd1, 8'd4);
    wait_sw(ok);
    check("ensmp_sw_seen", {31'd0, ok}, 32'd1);
    en = 1'b0;
    #1;
    snap_vld = n_vld; snap_done = n_done;
    @(posedge clk);
    @(negedge clk);
    check("ensmp_idle dischg/sw/hold/req/busy",
          {o_dischg, o_smp_sw, o_hold, o_conv_req, o_busy}, 12'd0);
    repeat (4) @(posedge clk);
    check("ensmp_no_strobes", n_vld - snap_vld + n_done - snap_done, 32'd0);
    @(negedge clk);
    en = 1'b1;

    // EN dropped in CONV with late ack: handshake completes, result delivered.
    @(negedge clk);
    start(8'h03, 8'd1, 8'd1);
    wait_req(ok, seen);
    check("enconv_req_seen", {31'd0, ok}, 32'd1);
    en = 1'b0;
    #1;
    snap_vld = n_vld; snap_done = n_done;
    held = 1'b1;
    repeat (5) begin
      @(negedge clk);
      held = held & o_conv_req & o_hold;
    end
    check("enconv_req_held", {31'd0, held}, 32'd1);
    do_ack(10'h1EE, 0);
    check("enconv_res vld/done/busy/req/dischg/ch/data",
          {o_res_vld, o_scan_done, o_busy, o_conv_req, o_dischg, o_res_ch, o_res_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h1EE});
    repeat (3) @(posedge clk);
    check("enconv_strobe_counts", {n_vld - snap_vld, n_done - snap_done}, {32'd1, 32'd0});
    @(negedge clk);
    en = 1'b1;

    // Asynchronous reset in SAMPLE, then a fresh scan.
    @(negedge clk);
    start(8'h01, 8'd1, 8'd5);
    wait_sw(ok);
    check("rst_sw_seen", {31'd0, ok}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {5'd0, act_vec()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_release", {5'd0, act_vec()}, 32'd0);
    start(8'h04, 8'd1, 8'd1);
    check("rst_fresh_dischg/busy", {o_dischg, o_busy, o_smp_sw}, {1'b1, 1'b1, 8'h00});
    wait_req(ok, seen);
    check("rst_fresh_sw", {23'd0, ok, seen}, {23'd0, 1'b1, 8'h04});
    do_ack(10'h0F0, 0);
    check("rst_fresh_res vld/done/ch/data",
          {o_res_vld, o_scan_done, o_res_ch, o_res_data},
          {1'b1, 1'b1, 3'd2, 10'h0F0});

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
